uart_rx_ctrl: RTL



---
 rtl/uart_rx_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_rx_ctrl
//  Description : Frame sequencing FSM for an oversampled UART receiver.
//                It walks the frame as START, DATA x8, optional PARITY,
//                STOP and DONE. It enables the external edge/bit counter and
//                the data sampler, and strobes the start, parity and stop
//                checkers and the deserializer at the mid-bit sample point.
//                It raises data_valid for one cycle when a byte is clean.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic [PRESC_W-1:0] edge_cnt,
  input  logic [3:0]         bit_cnt,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic               cnt_en,
  output logic               dat_samp_en,
  output logic               strt_chk_en,
  output logic               deser_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               data_valid
);

  // Binary state encoding. Codes 6 and 7 are unused and fall back to IDLE.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Frame bit indices as reported by the external bit counter
  localparam logic [3:0] BIT_START     = 4'd0;
  localparam logic [3:0] BIT_FIRST_DAT = 4'd1;
  localparam logic [3:0] BIT_LAST_DAT  = 4'd8;
  localparam logic [3:0] BIT_NINE      = 4'd9;
  localparam logic [3:0] BIT_TEN       = 4'd10;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       par_en_q;
  logic       par_en_d;

  // Edge-counter landmarks within one bit period
  logic [PRESC_W-1:0] w_samp_pt;   // mid-bit sample point, P/2+2
  logic [PRESC_W-1:0] w_bit_end;   // last oversample of a bit, P-1
  logic [PRESC_W-1:0] w_stop_end;  // stop bit is cut short one past the sample
  logic               w_at_samp;
  logic               w_at_end;
  logic               w_at_stop_end;

  // Bit-index qualifiers; a counter value that does not fit the current
  // state suppresses both strobes and transitions.
  logic w_bit_is_start;
  logic w_bit_is_data;
  logic w_bit_is_last_data;
  logic w_bit_is_parity;
  logic w_bit_is_stop;

  assign w_samp_pt     = (Prescale >> 1) + PRESC_W'(2);
  assign w_bit_end     = Prescale - PRESC_W'(1);
  assign w_stop_end    = w_samp_pt + PRESC_W'(1);

  assign w_at_samp     = (edge_cnt == w_samp_pt);
  assign w_at_end      = (edge_cnt == w_bit_end);
  assign w_at_stop_end = (edge_cnt == w_stop_end);

  assign w_bit_is_start     = (bit_cnt == BIT_START);
  assign w_bit_is_data      = (bit_cnt >= BIT_FIRST_DAT) && (bit_cnt <= BIT_LAST_DAT);
  assign w_bit_is_last_data = (bit_cnt == BIT_LAST_DAT);
  assign w_bit_is_parity    = (bit_cnt == BIT_NINE);
  // The stop bit follows the parity bit when parity is enabled for this frame
  assign w_bit_is_stop      = par_en_q ? (bit_cnt == BIT_TEN) : (bit_cnt == BIT_NINE);

  // State register and per-frame parity-enable latch
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      par_en_q <= par_en_d;
    end
  end

  // Next-state logic; PAR_EN is sampled only when a new frame begins
  always_comb begin
    state_d  = state_q;
    par_en_d = par_en_q;
    case (state_q)
      ST_IDLE: begin
        if (!RX_IN) begin
          state_d  = ST_START;
          par_en_d = PAR_EN;
        end
      end
      ST_START: begin
        if (w_at_end && w_bit_is_start) begin
          state_d = strt_glitch ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_at_end && w_bit_is_last_data) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (w_at_end && w_bit_is_parity) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_at_stop_end && w_bit_is_stop) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // A low line here is the start bit of a back-to-back frame
        if (!RX_IN) begin
          state_d  = ST_START;
          par_en_d = PAR_EN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        par_en_d = 1'b0;
      end
    endcase
  end

  // Output decode from state, edge counter and bit index
  always_comb begin
    cnt_en      = 1'b0;
    dat_samp_en = 1'b0;
    strt_chk_en = 1'b0;
    deser_en    = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    case (state_q)
      ST_START: begin
        cnt_en      = 1'b1;
        dat_samp_en = 1'b1;
        strt_chk_en = w_at_samp && w_bit_is_start;
      end
      ST_DATA: begin
        cnt_en      = 1'b1;
        dat_samp_en = 1'b1;
        deser_en    = w_at_samp && w_bit_is_data;
      end
      ST_PARITY: begin
        cnt_en      = 1'b1;
        dat_samp_en = 1'b1;
        par_chk_en  = w_at_samp && w_bit_is_parity;
      end
      ST_STOP: begin
        cnt_en      = 1'b1;
        dat_samp_en = 1'b1;
        stp_chk_en  = w_at_samp && w_bit_is_stop;
      end
      ST_DONE: begin
        // Parity error only matters when this frame carried a parity bit
        data_valid = !stp_err && (!par_en_q || !par_err);
      end
      default: begin
        cnt_en = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
